// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - tile-map pixel renderer with queued tile writes; optional PLAYER_SPRITE_EN sprite overlay
// Map is cleared after every reset, then written only during vertical blanking.
module tile_renderer #(
   parameter int TILES_X = 20,
   parameter int TILES_Y = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p_tick,
   input  logic [9:0]  x_pos,
   input  logic [9:0]  y_pos,
   input  logic        tile_we,
   input  logic [8:0]  tile_addr,
   input  logic [1:0]  tile_wdata,
   output logic        tile_ready,
   input  logic [9:0]  player_x,
   input  logic [9:0]  player_y,
   output logic [11:0] pix_data,
   output logic        display_on
);

   localparam int          N    = TILES_X * TILES_Y;
   localparam int          AW   = $clog2(N);
   localparam logic [15:0] N16  = 16'(N);
   localparam logic [15:0] TX16 = 16'(TILES_X);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t      state, state_nxt;
   logic [15:0] clr_cnt;
   logic        clr_we;

   logic [1:0]  tile_map [0:N-1];

   logic [8:0]  fifo_addr [0:3];
   logic [1:0]  fifo_data [0:3];
   logic [1:0]  wr_ptr, rd_ptr;
   logic [2:0]  count;
   logic        push, pop;
   logic [15:0] head16;
   logic        head_ok;

   logic [15:0] idx_mul;
   logic [9:0]  s0_x, s0_y, s1_x, s1_y;
   logic [15:0] s0_idx;
   logic [1:0]  s1_tile;
   logic        vis;
   logic [11:0] colour;

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_CLEAR;
      else      state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      if (state == ST_CLEAR && clr_cnt == N16 - 16'd1)
         state_nxt = ST_RUN;
   end

   // FSM: outputs
   always_comb begin
      clr_we     = (state == ST_CLEAR);
      tile_ready = (state == ST_RUN) && (count != 3'd4);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  clr_cnt <= 16'd0;
      else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 16'd1;
   end

   assign push    = tile_we && tile_ready;
   assign pop     = (state == ST_RUN) && (count != 3'd0) && (y_pos >= 10'd480);
   assign head16  = {7'd0, fifo_addr[rd_ptr]};
   assign head_ok = head16 < N16;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         count <= count + {2'd0, push} - {2'd0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= tile_addr;
         fifo_data[wr_ptr] <= tile_wdata;
      end
   end

   // Out-of-range queued addresses are popped but never written.
   always_ff @(posedge clk) begin
      if (clr_we)
         tile_map[clr_cnt[AW-1:0]] <= 2'd0;
      else if (pop && head_ok)
         tile_map[head16[AW-1:0]] <= fifo_data[rd_ptr];
   end

   // Row * TILES_X as a constant shift-and-add network.
   always_comb begin
      idx_mul = 16'd0;
      for (int b = 0; b < 16; b++)
         if (TX16[b]) idx_mul = idx_mul + ({11'd0, y_pos[9:5]} << b);
      idx_mul = idx_mul + {11'd0, x_pos[9:5]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_x    <= 10'd0;
         s0_y    <= 10'd0;
         s0_idx  <= 16'd0;
         s1_x    <= 10'd0;
         s1_y    <= 10'd0;
         s1_tile <= 2'd0;
      end else if (p_tick) begin
         s0_x    <= x_pos;
         s0_y    <= y_pos;
         s0_idx  <= idx_mul;
         s1_x    <= s0_x;
         s1_y    <= s0_y;
         s1_tile <= (s0_idx < N16) ? tile_map[s0_idx[AW-1:0]] : 2'd0;
      end
   end

`ifndef PLAYER_SPRITE_EN
   logic unused_player;
   assign unused_player = ^{player_x, player_y};
`endif

   always_comb begin
      vis = (s1_x < 10'd640) && (s1_y < 10'd480);
      case (s1_tile)
         2'd0:    colour = 12'h0A0;
         2'd1:    colour = 12'h888;
         2'd2:    colour = (s1_x[4:0] == 5'd0 || s1_y[4:0] == 5'd0) ? 12'h631 : 12'hA52;
         default: colour = 12'h222;
      endcase
`ifdef PLAYER_SPRITE_EN
      // 11-bit compares so a sprite near 1023 does not wrap to the left edge.
      if ({1'b0, s1_x} >= {1'b0, player_x} && {1'b0, s1_x} <= {1'b0, player_x} + 11'd31 &&
          {1'b0, s1_y} >= {1'b0, player_y} && {1'b0, s1_y} <= {1'b0, player_y} + 11'd31)
         colour = 12'hFFF;
`endif
      if (!vis) colour = 12'h000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_data   <= 12'h000;
         display_on <= 1'b0;
      end else if (state != ST_RUN) begin
         pix_data   <= 12'h000;
         display_on <= 1'b0;
      end else if (p_tick) begin
         pix_data   <= colour;
         display_on <= vis;
      end
   end

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - randomized bench for tile_renderer against a tile-map reference model
module tb_tile_renderer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        p_tick = 1'b0;
   logic [9:0]  x_pos = 10'd0, y_pos = 10'd0;
   logic        tile_we = 1'b0;
   logic [8:0]  tile_addr = 9'd0;
   logic [1:0]  tile_wdata = 2'd0;
   logic        tile_ready;
   logic [9:0]  player_x = 10'd0, player_y = 10'd0;
   logic [11:0] pix_data;
   logic        display_on;

   tile_renderer dut (
      .clk(clk), .rst(rst), .p_tick(p_tick), .x_pos(x_pos), .y_pos(y_pos),
      .tile_we(tile_we), .tile_addr(tile_addr), .tile_wdata(tile_wdata),
      .tile_ready(tile_ready), .player_x(player_x), .player_y(player_y),
      .pix_data(pix_data), .display_on(display_on)
   );

   always #5 clk = ~clk;

   typedef struct { int addr; int data; } wr_t;
   typedef struct { logic [11:0] pix; logic on; } px_t;

   int   checks = 0, errors = 0;
   int   ref_map [300];
   wr_t  pend [$];
   px_t  exp_q [$];
   px_t  last_exp;
   bit   have_last = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] ref_col(input int x, input int y);
      int t;
      if (x >= 640 || y >= 480) return 12'h000;
`ifdef PLAYER_SPRITE_EN
      if (x >= int'(player_x) && x <= int'(player_x) + 31 &&
          y >= int'(player_y) && y <= int'(player_y) + 31) return 12'hFFF;
`endif
      t = ref_map[(y / 32) * 20 + x / 32];
      case (t)
         0:       return 12'h0A0;
         1:       return 12'h888;
         2:       return (x % 32 == 0 || y % 32 == 0) ? 12'h631 : 12'hA52;
         default: return 12'h222;
      endcase
   endfunction

   function automatic void apply(input wr_t w);
      if (w.addr < 300) ref_map[w.addr] = w.data;
   endfunction

   // One clk with an optional write; the queue model pops during vblank.
   task automatic step(input bit we, input int addr, input int data);
      int  sz;
      bit  rdy;
      wr_t w;
      sz  = pend.size();
      rdy = (sz < 4);
      tile_we = we; tile_addr = addr[8:0]; tile_wdata = data[1:0];
      if (we) chk("tile_ready", {31'd0, tile_ready}, {31'd0, rdy});
      @(posedge clk); #1;
      tile_we = 1'b0;
      if (y_pos >= 480 && sz > 0) apply(pend.pop_front());
      if (we && rdy) begin
         w.addr = addr; w.data = data;
         pend.push_back(w);
      end
   endtask

   task automatic drain();
      y_pos = 10'd500;
      repeat (6) step(0, 0, 0);
      chk("ready_after_drain", {31'd0, tile_ready}, 32'd1);
      y_pos = 10'd100;
   endtask

   task automatic pix(input int x, input int y);
      px_t e;
      x_pos = x[9:0]; y_pos = y[9:0]; p_tick = 1'b1;
      @(posedge clk); #1;
      p_tick = 1'b0;
      e.pix = ref_col(x, y);
      e.on  = (x < 640 && y < 480);
      exp_q.push_back(e);
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         chk("pix_data", {20'd0, pix_data}, {20'd0, e.pix});
         chk("display_on", {31'd0, display_on}, {31'd0, e.on});
         last_exp = e; have_last = 1;
      end
      repeat ($urandom_range(0, 1)) begin
         @(posedge clk); #1;
         if (have_last) chk("pix_hold", {20'd0, pix_data}, {20'd0, last_exp.pix});
      end
   endtask

   task automatic flush();
      pix(700, 100);
      pix(700, 100);
   endtask

   task automatic scan_rand(input int n);
      for (int i = 0; i < n; i++)
         pix($urandom_range(0, 700), (pend.size() != 0) ? $urandom_range(0, 479) : $urandom_range(0, 520));
      flush();
   endtask

   task automatic scan_map();
      for (int ty = 0; ty < 15; ty++)
         for (int tx = 0; tx < 20; tx++)
            pix(tx * 32 + $urandom_range(0, 31), ty * 32 + $urandom_range(0, 31));
      flush();
   endtask

   // Reset is already asserted on entry; releases it and times CLEAR.
   task automatic release_and_clear();
      int n;
      pend.delete(); exp_q.delete(); have_last = 0;
      foreach (ref_map[i]) ref_map[i] = 0;
      @(posedge clk); #1;
      rst = 1'b1;
      x_pos = 10'd10; y_pos = 10'd10;
      n = 0;
      while (!tile_ready && n < 1000) begin
         p_tick = 1'b1;
         @(posedge clk); #1;
         n++;
         if (n == 150) begin
            chk("clear_display_on", {31'd0, display_on}, 32'd0);
            chk("clear_pix", {20'd0, pix_data}, 32'd0);
         end
      end
      p_tick = 1'b0;
      chk("clear_cycles", n, 300);
   endtask

   initial begin
      int a, last_a;
      player_x = 10'($urandom_range(0, 1023));
      player_y = 10'($urandom_range(0, 1023));
      #2 rst = 1'b0;
      #1;
      chk("rst_ready", {31'd0, tile_ready}, 32'd0);
      chk("rst_display_on", {31'd0, display_on}, 32'd0);
      chk("rst_pix", {20'd0, pix_data}, 32'd0);
      repeat (3) @(posedge clk);
      release_and_clear();

      // First frame: all floor
      scan_map();
      scan_rand(100);
      pix(700, 10); pix(639, 479); pix(640, 0); pix(0, 480);
      flush();

      // Single wall tile at index 21
      y_pos = 10'd100;
      step(1, 21, 1);
      drain();
      pix(32, 32); pix(63, 63); pix(31, 32); pix(64, 63); pix(32, 64); pix(50, 31);
      flush();
      scan_map();

      // Five back-to-back writes in the visible area; last one must be refused
      y_pos = 10'd100;
      a = $urandom_range(0, 299);
      step(1, a, 1);
      step(1, $urandom_range(0, 299), 3);
      step(1, $urandom_range(0, 299), 2);
      step(1, a, 3);
      chk("fifo_full_ready", {31'd0, tile_ready}, 32'd0);
      step(1, a, 2);
      chk("fifo_pending", pend.size(), 4);
      scan_rand(120);
      drain();
      scan_map();

      // Brick mortar and out-of-range write
      step(1, 0, 2);
      step(1, 300, 3);
      step(1, 511, 1);
      drain();
      pix(0, 5); pix(7, 0); pix(5, 5); pix(31, 31); pix(700, 5);
      flush();
      scan_map();

      // Random write batches, visible or overlapping vblank drain
      last_a = 0;
      for (int r = 0; r < 6; r++) begin
         y_pos = ($urandom_range(0, 1) != 0) ? 10'd100 : 10'd500;
         for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
            a = ($urandom_range(0, 3) == 0) ? last_a : $urandom_range(0, 511);
            last_a = a;
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3));
         end
         drain();
         scan_map();
      end

      // Sprite overlay
      player_x = 10'd100; player_y = 10'd100;
      pix(131, 131); pix(132, 100); pix(100, 100); pix(99, 100); pix(100, 132);
      for (int i = 0; i < 40; i++) pix($urandom_range(80, 150), $urandom_range(80, 150));
      flush();

      // Mid-run reset with writes still queued
      y_pos = 10'd100;
      step(1, 5, 3);
      step(1, 6, 1);
      rst = 1'b0;
      #2;
      chk("midrst_ready", {31'd0, tile_ready}, 32'd0);
      chk("midrst_display_on", {31'd0, display_on}, 32'd0);
      chk("midrst_pix", {20'd0, pix_data}, 32'd0);
      release_and_clear();
      drain();
      scan_map();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tile_renderer.md
TILE_RENDERER -- requirements
Module: tile_renderer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; single clock domain.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: p_tick  in  1  pixel strobe from the VGA driver, one clk wide.
REQ-004 SHALL have ports: x_pos  in  10  current scan column; y_pos  in  10  current scan row.
REQ-005 SHALL have ports: tile_we  in  1  tile-write request; tile_addr  in  9  tile index; tile_wdata  in  2  tile type.
REQ-006 SHALL have ports: tile_ready  out  1  write accepted in the cycle where tile_we=1 and tile_ready=1.
REQ-007 SHALL have ports: player_x  in  10, player_y  in  10  player sprite top-left pixel.
REQ-008 SHALL have ports: pix_data  out  12  RGB444 colour {R,G,B}; display_on  out  1  pixel lies in the visible 640x480 area.
REQ-009 SHALL have parameters: TILES_X, default 20, map columns; TILES_Y, default 15, map rows; tiles are fixed at 32x32 px.

Function
REQ-010 SHALL hold a TILES_X*TILES_Y x 2-bit tile map, indexed (y_pos[9:5]*TILES_X + x_pos[9:5]); the multiply uses shifts and adds only.
REQ-011 SHALL advance a 3-stage pipeline only on p_tick: S0 registers x/y and the index, S1 performs the synchronous map read, S2 muxes the colour and registers outputs.
REQ-012 SHALL present pix_data and display_on for a given x_pos/y_pos exactly 2 p_ticks after the p_tick that sampled them; outputs hold between p_ticks.
REQ-013 SHALL drive display_on=1 iff the sampled x<640 and y<480; pix_data SHALL be 12'h000 whenever display_on=0.
REQ-014 SHALL use the palette: type0 floor 12'h0A0; type1 wall 12'h888; type2 brick 12'hA52, with mortar 12'h631 where x[4:0]==0 or y[4:0]==0; type3 bomb 12'h222.
REQ-015 SHALL implement the state machine CLEAR->RUN; CLEAR writes 0 to every map entry, one per clk in ascending address order, then enters RUN; RUN never exits except via reset.
REQ-016 SHALL, in CLEAR, hold tile_ready=0, display_on=0 and pix_data=12'h000.
REQ-017 SHALL buffer accepted writes in a 4-entry FIFO; tile_ready=1 iff state is RUN and the FIFO is not full.
REQ-018 SHALL drain at most one FIFO entry per clk into the map, only while y_pos>=480 (vertical blanking), so a visible frame never tears.
REQ-019 SHALL discard an entry whose tile_addr>=TILES_X*TILES_Y at drain time, with no map change.
REQ-020 SHALL, when push and pop occur in the same clk, keep the occupancy unchanged and preserve FIFO order.
REQ-021 SHALL, when several writes to one address are queued, leave the last-accepted value in the map.

Reset
REQ-022 SHALL, on rst=0, asynchronously clear the FIFO (empty), clear the pipeline, set pix_data=12'h000, display_on=0 and tile_ready=0, and enter CLEAR.
REQ-023 SHALL, when rst is asserted mid-frame or mid-CLEAR, restart CLEAR from address 0 after release; map contents are invalid until CLEAR completes.

Configuration
REQ-024 SHALL, with PLAYER_SPRITE_EN defined, overlay 12'hFFF in S2 for x in [player_x, player_x+31] and y in [player_y, player_y+31], using 11-bit compares so there is no wrap; the overlay applies only when display_on=1.
REQ-025 SHALL, with PLAYER_SPRITE_EN undefined, ignore player_x and player_y, keep the ports, and create no compare logic.

Verification
REQ-026 SHALL cover: reset release -> tile_ready=0 for exactly 300 clks, then 1; first frame is all 12'h0A0 in the visible area.
REQ-027 SHALL cover: write addr 21 type1 during RUN, then next frame -> pixels x 32..63, y 32..63 equal 12'h888 with 2-p_tick latency; other pixels 12'h0A0.
REQ-028 SHALL cover: 5 back-to-back writes during the visible area -> tile_ready drops after the 4th, and all 4 entries land during vblank with order kept.
REQ-029 SHALL cover: write type2 to addr 0 -> pixel (0,5) and pixel (7,0) equal 12'h631; pixel (5,5) equals 12'hA52.
REQ-030 SHALL cover: write addr 300 -> accepted, dropped, with no map change; x_pos=700 -> display_on=0 and pix_data=12'h000.
REQ-031 SHALL cover: with PLAYER_SPRITE_EN defined and player at (100,100) -> pixel (131,131) equals 12'hFFF and pixel (132,100) shows the tile colour.
